led_blink_ctrl: RTL and testbench

//  Multi-channel LED blink controller; generalises the single-LED switch-rate divider.

---
 rtl/led_blink_ctrl.sv | 127 ++++++++++++
 tb/tb_led_blink_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared prescaler, per-channel rate select,
// continuous or N-blink burst mode. Optional per-channel PWM brightness via LED_BLINK_PWM_EN.
module led_blink_ctrl #(
    parameter int CH    = 4,
    parameter int DIV_W = 27,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*CH-1:0]    rate_sel,
    input  logic [CH-1:0]      mode,
    input  logic [CH-1:0]      start,
    input  logic [CNT_W-1:0]   burst_len,
`ifdef LED_BLINK_PWM_EN
    input  logic [4*CH-1:0]    bright,
`endif
    output logic [CH-1:0]      led,
    output logic [CH-1:0]      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ON   = 2'd2,
        OFF  = 2'd3
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values and updates together; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Index 0 is the "off" rate and never ticks, so tick[rate] selects directly.
    assign tick = {&div_cnt[DIV_W-4:0], &div_cnt[DIV_W-3:0], &div_cnt[DIV_W-2:0], 1'b0};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           st;
        state_t           st_nxt;
        logic             burst;
        logic             burst_nxt;
        logic [CNT_W-1:0] rem;
        logic [CNT_W-1:0] rem_nxt;
        logic [1:0]       rate;
        logic             ch_tick;
        logic             led_c;
        logic             busy_c;

        assign rate    = rate_sel[2*i +: 2];
        assign ch_tick = tick[rate];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st    <= IDLE;
                burst <= 1'b0;
                rem   <= '0;
            end else begin
                st    <= st_nxt;
                burst <= burst_nxt;
                rem   <= rem_nxt;
            end
        end

        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        always_comb begin
            st_nxt    = st;
            burst_nxt = burst;
            rem_nxt   = rem;
            if (rate == 2'b00) begin
                st_nxt    = IDLE;
                burst_nxt = 1'b0;
                rem_nxt   = '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (!mode[i]) begin
                            st_nxt    = ARM;
                            burst_nxt = 1'b0;
                        end else if (start[i] && (burst_len != '0)) begin
                            st_nxt    = ARM;
                            burst_nxt = 1'b1;
                            rem_nxt   = burst_len;
                        end
                    end
                    ARM: begin
                        if (ch_tick) st_nxt = ON;
                    end
                    ON: begin
                        if (ch_tick) begin
                            st_nxt = OFF;
                            if (burst) rem_nxt = rem - CNT_W'(1);
                        end
                    end
                    OFF: begin
                        // Run type was latched on leaving IDLE; live mode only ends a continuous run.
                        if (ch_tick) begin
                            if (burst) st_nxt = (rem == '0) ? IDLE : ON;
                            else       st_nxt = mode[i] ? IDLE : ON;
                        end
                    end
                    default: st_nxt = IDLE;
                endcase
            end
        end

        always_comb begin
            busy_c = (st != IDLE);
`ifdef LED_BLINK_PWM_EN
            led_c  = (st == ON) && (div_cnt[3:0] < bright[4*i +: 4]);
`else
            led_c  = (st == ON);
`endif
        end

        assign led[i]  = led_c;
        assign busy[i] = busy_c;
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl (CH=4, DIV_W=5, CNT_W=4): directed vectors
// and hand-written multi-cycle sequences; PWM checks only when LED_BLINK_PWM_EN is defined.
module tb_led_blink_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rate_sel;
    logic [3:0]  mode;
    logic [3:0]  start;
    logic [3:0]  burst_len;
`ifdef LED_BLINK_PWM_EN
    logic [15:0] bright;
`endif
    logic [3:0]  led;
    logic [3:0]  busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    led_blink_ctrl #(.CH(4), .DIV_W(5), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rate_sel  (rate_sel),
        .mode      (mode),
        .start     (start),
        .burst_len (burst_len),
`ifdef LED_BLINK_PWM_EN
        .bright    (bright),
`endif
        .led       (led),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] start;
        logic [3:0] exp_led;
        logic [3:0] exp_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n clock cycles; cyc equals div_cnt (mod 32) since the last reset release.
    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic goto(input int target);
        adv(target - cyc);
    endtask

    task automatic apply_reset(input logic [7:0] rs, input logic [3:0] md);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_led_async", {28'd0, led}, 32'd0);
        check("rst_busy_async", {28'd0, busy}, 32'd0);
        check("rst_div_cnt", {27'd0, dut.div_cnt}, 32'd0);
        rate_sel  = rs;
        mode      = md;
        start     = 4'b0000;
        burst_len = 4'd3;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int pulses;
        int lit;
        int busy_cyc;
        int other_busy;
        logic prev;

        rst       = 1'b1;
        rate_sel  = 8'hFF;
        mode      = 4'b0000;
        start     = 4'b0000;
        burst_len = 4'd3;
`ifdef LED_BLINK_PWM_EN
        bright    = 16'hFFFF;
`endif
        repeat (2) @(negedge clk);
        check("init_led", {28'd0, led}, 32'd0);
        check("init_busy", {28'd0, busy}, 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Reset in the middle of a run, all channels fast.
        goto(1);
        check("t1_arm_busy", {28'd0, busy}, 32'hF);
        goto(5);
        check("t1_on_led", {28'd0, led}, 32'hF);
        apply_reset(8'hFF, 4'b0000);
        goto(1);
        check("t1_rearm_busy", {28'd0, busy}, 32'hF);
        check("t1_rearm_led", {28'd0, led}, 32'h0);
        goto(3);
        check("t1_pre_tick_led", {28'd0, led}, 32'h0);
        goto(4);
        check("t1_first_on_led", {28'd0, led}, 32'hF);

        // Continuous: ch0 slow, ch1 medium, ch2 fast, ch3 off; led = div_cnt bit (5-rate).
        vecs[0]  = '{0,  4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1,  4'b0000, 4'b0000, 4'b0111};
        vecs[2]  = '{3,  4'b0000, 4'b0000, 4'b0111};
        vecs[3]  = '{4,  4'b0111, 4'b0100, 4'b0111};
        vecs[4]  = '{7,  4'b0000, 4'b0100, 4'b0111};
        vecs[5]  = '{8,  4'b0000, 4'b0010, 4'b0111};
        vecs[6]  = '{12, 4'b0000, 4'b0110, 4'b0111};
        vecs[7]  = '{16, 4'b0000, 4'b0001, 4'b0111};
        vecs[8]  = '{20, 4'b0111, 4'b0101, 4'b0111};
        vecs[9]  = '{24, 4'b0000, 4'b0011, 4'b0111};
        vecs[10] = '{31, 4'b0000, 4'b0111, 4'b0111};
        vecs[11] = '{32, 4'b0000, 4'b0000, 4'b0111};
        vecs[12] = '{36, 4'b0000, 4'b0100, 4'b0111};
        vecs[13] = '{48, 4'b0000, 4'b0001, 4'b0111};
        apply_reset(8'b00_11_10_01, 4'b0000);
        for (int k = 0; k < 14; k++) begin
            goto(vecs[k].cyc);
            check($sformatf("t2_led_c%0d", vecs[k].cyc), {28'd0, led}, {28'd0, vecs[k].exp_led});
            check($sformatf("t2_busy_c%0d", vecs[k].cyc), {28'd0, busy}, {28'd0, vecs[k].exp_busy});
            if (vecs[k].start != 4'b0000) begin
                start = vecs[k].start;
                adv(1);
                start = 4'b0000;
            end
        end

        // Burst of 3 on ch0 (fast), with ignored starts mixed in.
        apply_reset(8'b00_00_00_11, 4'b0001);
        check("t3_idle_busy", {28'd0, busy}, 32'h0);
        start = 4'b0001;
        adv(1);
        start = 4'b0000;
        check("t3_arm_busy", {31'd0, busy[0]}, 32'd1);
        pulses = 0; lit = 0; busy_cyc = 0; other_busy = 0; prev = 1'b0;
        for (int k = 0; k < 59; k++) begin
            start     = (cyc == 10 || cyc == 40) ? 4'b0001 : (cyc == 50 ? 4'b0010 : 4'b0000);
            burst_len = (cyc == 40) ? 4'd0 : 4'd3;
            if (led[0] && !prev) pulses++;
            if (led[0]) lit++;
            if (busy[0]) busy_cyc++;
            if (busy[3:1] != 3'b000) other_busy++;
            prev = led[0];
            adv(1);
        end
        start = 4'b0000;
        check("t3_pulse_count", pulses, 32'd3);
        check("t3_lit_cycles", lit, 32'd12);
        check("t3_busy_cycles", busy_cyc, 32'd27);
        check("t4_other_ch_busy", other_busy, 32'd0);
        // Restart with burst_len=2 sampled on the accepted start.
        burst_len = 4'd2;
        start = 4'b0001;
        adv(1);
        start = 4'b0000;
        burst_len = 4'd7;
        check("t3b_busy", {31'd0, busy[0]}, 32'd1);
        goto(64);
        check("t3b_on", {31'd0, led[0]}, 32'd1);
        goto(79);
        check("t3b_last_off_led", {31'd0, led[0]}, 32'd0);
        check("t3b_last_off_busy", {31'd0, busy[0]}, 32'd1);
        goto(80);
        check("t3b_done_busy", {31'd0, busy[0]}, 32'd0);

        // Rate to off mid-ON, then slow -> medium mid-run.
        apply_reset(8'h03, 4'b0000);
        goto(5);
        check("t5_on_led", {31'd0, led[0]}, 32'd1);
        rate_sel = 8'h00;
        adv(1);
        check("t5_off_led", {31'd0, led[0]}, 32'd0);
        check("t5_off_busy", {31'd0, busy[0]}, 32'd0);
        rate_sel = 8'h01;
        adv(1);
        check("t5_rearm_busy", {31'd0, busy[0]}, 32'd1);
        goto(15);
        check("t5_slow_pre", {31'd0, led[0]}, 32'd0);
        goto(16);
        check("t5_slow_on", {31'd0, led[0]}, 32'd1);
        goto(20);
        rate_sel = 8'h02;
        goto(23);
        check("t5_med_pre", {31'd0, led[0]}, 32'd1);
        goto(24);
        check("t5_med_off", {31'd0, led[0]}, 32'd0);
        goto(32);
        check("t5_med_on", {31'd0, led[0]}, 32'd1);

`ifdef LED_BLINK_PWM_EN
        apply_reset(8'h01, 4'b0000);
        bright = 16'h0008;
        goto(16);
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            if (led[0]) lit++;
            adv(1);
        end
        check("t6_pwm8_lit", lit, 32'd8);
        bright = 16'h0000;
        goto(48);
        check("t6_pwm0_busy", {31'd0, busy[0]}, 32'd1);
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            if (led[0]) lit++;
            adv(1);
        end
        check("t6_pwm0_lit", lit, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
